// File: rtl/multdiv_seq_unit_pkg.sv
// Shared constants and types for the sequential multiply/divide unit.
package multdiv_seq_unit_pkg;

  localparam int ITERS = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  // Two's complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_iter_step.sv
// One combinational iteration of the shared multiply/divide datapath.
// Multiply: hi is a sign-extended 33-bit partial product, lo holds the
// remaining multiplier bits; the last step subtracts because the multiplier
// sign bit carries weight -2^31.
// Divide: hi is the 33-bit signed partial remainder, lo shifts the dividend
// out at the top and the quotient bits in at the bottom (non-restoring).
module multdiv_iter_step
  import multdiv_seq_unit_pkg::*;
(
  input  op_e         op_i,
  input  logic        last_i,
  input  logic [32:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] b_i,
  output logic [32:0] hi_o,
  output logic [31:0] lo_o
);

  logic [32:0] b_sext;
  logic [32:0] b_zext;
  logic [32:0] m_sum;
  logic [32:0] r_sh;
  logic [32:0] r_new;

  assign b_sext = {b_i[31], b_i};
  assign b_zext = {1'b0, b_i};

  // Add or subtract the operand, then shift by one in the op's direction.
  always_comb begin
    m_sum = hi_i;
    r_sh  = {hi_i[31:0], lo_i[31]};
    r_new = r_sh;
    hi_o  = hi_i;
    lo_o  = lo_i;
    if (op_i == OP_MULT) begin
      if (lo_i[0]) m_sum = last_i ? (hi_i - b_sext) : (hi_i + b_sext);
      hi_o = {m_sum[32], m_sum[32:1]};
      lo_o = {m_sum[0], lo_i[31:1]};
    end else begin
      r_new = hi_i[32] ? (r_sh + b_zext) : (r_sh - b_zext);
      hi_o  = r_new;
      lo_o  = {lo_i[30:0], ~r_new[32]};
    end
  end

endmodule

// File: rtl/multdiv_seq_unit.sv
// Sequential signed 32-bit multiply / divide, fixed 33-cycle latency.
// Start edge loads operands, 32 iteration edges follow, and the 33rd edge
// registers the fixed-up result and raises data_resultRDY for one cycle.
module multdiv_seq_unit
  import multdiv_seq_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ctrl_mult,
  input  logic        ctrl_div,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              iters_done_q;
  op_e               op_q;
  logic [32:0]       hi_q;
  logic [31:0]       lo_q;
  logic [31:0]       b_q;
  logic              neg_q;
  logic              bzero_q;
  logic [31:0]       result_q;
  logic              exc_q;
  logic              rdy_q;
  logic              busy_q;

  logic [32:0]       step_hi;
  logic [31:0]       step_lo;
  logic              start;
  op_e               start_op;
  logic [31:0]       fin_res_d;
  logic              fin_exc_d;
  logic [32:0]       prod_top;
  logic [31:0]       quot_mag;

  // Exactly one ctrl line high, and only when no operation is running.
  assign start    = (ctrl_mult ^ ctrl_div) && (state_q != S_RUN);
  assign start_op = ctrl_div ? OP_DIV : OP_MULT;

  multdiv_iter_step u_step (
    .op_i   (op_q),
    .last_i (cnt_q == CNT_LAST),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .b_i    (b_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Final result and flag from the accumulator once all iterations are done.
  always_comb begin
    prod_top  = {hi_q[31:0], lo_q[31]};
    quot_mag  = lo_q;
    fin_res_d = lo_q;
    fin_exc_d = ~((&prod_top) | ~(|prod_top));
    if (op_q == OP_DIV) begin
      if (bzero_q) begin
        fin_res_d = 32'd0;
        fin_exc_d = 1'b1;
      end else begin
        fin_res_d = neg_q ? (~quot_mag + 32'd1) : quot_mag;
        // Only a positive quotient can exceed the signed range (MIN / -1).
        fin_exc_d = ~neg_q & quot_mag[31];
      end
    end
  end

  // Control FSM, iteration counter, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      iters_done_q <= 1'b0;
      op_q         <= OP_MULT;
      hi_q         <= '0;
      lo_q         <= '0;
      b_q          <= '0;
      neg_q        <= 1'b0;
      bzero_q      <= 1'b0;
      result_q     <= '0;
      exc_q        <= 1'b0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (!iters_done_q) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) iters_done_q <= 1'b1;
          end else begin
            result_q     <= fin_res_d;
            exc_q        <= fin_exc_d;
            rdy_q        <= 1'b1;
            busy_q       <= 1'b0;
            iters_done_q <= 1'b0;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          if (!start) state_q <= S_IDLE;
        end
        default: ;
      endcase
      // Start overrides the IDLE/DONE handling above.
      if (start) begin
        state_q      <= S_RUN;
        busy_q       <= 1'b1;
        cnt_q        <= '0;
        iters_done_q <= 1'b0;
        op_q         <= start_op;
        hi_q         <= '0;
        neg_q        <= data_operandA[31] ^ data_operandB[31];
        bzero_q      <= (data_operandB == 32'd0);
        if (start_op == OP_DIV) begin
          lo_q <= abs32(data_operandA);
          b_q  <= abs32(data_operandB);
        end else begin
          lo_q <= data_operandB;
          b_q  <= data_operandA;
        end
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_seq_unit.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops
// and compares value, flag and latency on every data_resultRDY.
module tb_multdiv_seq_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_mult = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct {
    logic [31:0] r;
    logic        e;
    int          st;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic prev_rdy = 1'b0;

  multdiv_seq_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Monitor: every RDY must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t x;
    if (reset_n && data_resultRDY) begin
      chk("rdy_single_cycle", {31'd0, prev_rdy}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_rdy", 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        chk("result", data_result, x.r);
        chk("exception", {31'd0, data_exception}, {31'd0, x.e});
        chk("latency", 32'(cyc - x.st), 32'd33);
      end
    end
    prev_rdy = data_resultRDY;
  end

  // Drive a start at the current negedge; the next posedge is the start edge.
  task automatic issue(input logic m, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee);
    exp_t x;
    ctrl_mult = m;
    ctrl_div = ~m;
    data_operandA = a;
    data_operandB = b;
    x.r = er;
    x.e = ee;
    x.st = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    ctrl_mult = 1'b0;
    ctrl_div = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Returns at the negedge where RDY is high, or flags a timeout.
  task automatic wait_rdy(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (data_resultRDY) seen = 1'b1;
    end
    chk({nm, "_timeout"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic run_op(input string nm, input logic m, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ee);
    @(negedge clk);
    issue(m, a, b, er, ee);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    wait_rdy(nm);
    @(negedge clk);
    chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({nm, "_rdy_low"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_result", data_result, 32'd0);
    chk("rst_exc", {31'd0, data_exception}, 32'd0);
    chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op("mul_7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run_op("div_-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_result", data_result, 32'hFFFF_FFFD);
    chk("hold_exc", {31'd0, data_exception}, 32'd0);
    run_op("div_5/0", 1'b0, 32'd5, 32'd0, 32'd0, 1'b1);
    run_op("div_min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("mul_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);

    // Reset partway through a multiply: everything clears, no RDY for it.
    @(negedge clk);
    issue(1'b1, 32'd3, 32'd4, 32'd12, 1'b0);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_result", data_result, 32'd0);
    chk("abort_exc", {31'd0, data_exception}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (45) @(negedge clk);
    run_op("mul_after_rst", 1'b1, 32'd6, 32'd7, 32'd42, 1'b0);

    // Back-to-back: second start lands on the DONE cycle.
    @(negedge clk);
    issue(1'b1, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
    wait_rdy("b2b_mul");
    issue(1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge clk);
    // Pulses during RUN must be ignored.
    ctrl_div = 1'b1;
    data_operandA = 32'd1;
    data_operandB = 32'd1;
    @(negedge clk);
    ctrl_div = 1'b0;
    ctrl_mult = 1'b1;
    @(negedge clk);
    ctrl_mult = 1'b0;
    wait_rdy("b2b_div");

    // Both ctrl lines together: no start.
    repeat (2) @(negedge clk);
    ctrl_mult = 1'b1;
    ctrl_div = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    @(negedge clk);
    ctrl_mult = 1'b0;
    ctrl_div = 1'b0;
    chk("both_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("both_result_held", data_result, 32'd14);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
